pool_max_sequencer: RTL
=======================

// Module: pool_max_sequencer
// PURPOSE
//   Max-pooling sequencer; initiator side of the floating comparator interface.
//   - Accepts a stream of IEEE-754 single-precision values, one per handshake.
//   - For each window of POOL_SIZE values, issues operand pairs (running max, new
//     value) to an external floating comparator and reads back gt/result.
//   - Emits the window maximum and the in-window index of its first occurrence.
//   - Sits between the conv output buffer and the next layer's input buffer.
// PARAMETERS
//   DATA_WIDTH  32  operand width; matches `DATA_WIDTH in global_define.v
//   POOL_SIZE   4   values per pooling window, legal range 1..255
//   IDX_WIDTH   8   width of out_idx and of the internal element counter
// PORTS
//   clk        in   1           system clock, rising edge
//   rst        in   1           asynchronous reset, active-high
//   in_valid   in   1           in_data is valid
//   in_ready   out  1           block accepts in_data this cycle
//   in_data    in   DATA_WIDTH  float operand
//   cmp_a      out  DATA_WIDTH  comparator operand a (running max), registered
//   cmp_b      out  DATA_WIDTH  comparator operand b (new value), registered
//   cmp_gt     in   1           comparator: a > b
//   cmp_result in   DATA_WIDTH  comparator: larger of a, b
//   out_valid  out  1           out_data/out_idx valid
//   out_ready  in   1           downstream accepts the output
//   out_data   out  DATA_WIDTH  window maximum
//   out_idx    out  IDX_WIDTH   index (0-based) of first occurrence of the max
//   win_count  out  16          windows emitted since reset; wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (async, rst=1)
//     - All outputs and registers go to 0; state=IDLE.
//     - Takes effect immediately, including mid-window or while out_valid=1.
//     - A partial window is discarded.
//   Input transfer: in_valid & in_ready at a rising clk edge.
//   Output transfer: out_valid & out_ready at a rising clk edge.
//   Comparator timing
//     - The comparator is combinational.
//     - cmp_a/cmp_b are registered; cmp_gt/cmp_result are sampled on the
//       edge after the operands are loaded.
//     - cmp_a/cmp_b hold their last value outside WAIT.
//   States
//     IDLE
//       - in_ready=1, out_valid=0.
//       - On transfer: max_reg<=in_data, idx_reg<=0, cnt<=1.
//       - Next state: OUT if POOL_SIZE==1, else ACCUM.
//     ACCUM
//       - in_ready=1.
//       - On transfer: cmp_a<=max_reg, cmp_b<=in_data, cur_idx<=cnt, cnt<=cnt+1,
//         then ->WAIT. Stays in ACCUM otherwise.
//     WAIT (exactly 1 cycle)
//       - in_ready=0.
//       - max_reg<=cmp_result.
//       - idx_reg<=cur_idx only if cmp_gt==0 and cmp_a!=cmp_b (bitwise), so
//         ties keep the earliest index.
//       - Next state: OUT if cnt==POOL_SIZE, else ACCUM.
//     OUT
//       - in_ready=0; out_valid=1; out_data=max_reg; out_idx=idx_reg.
//       - Outputs are held stable while out_ready=0.
//       - On transfer: win_count++ and ->IDLE.
//   Throughput and latency
//     - Steady-state throughput is 1 element per 2 cycles.
//     - Minimum latency from the last input transfer to out_valid is 2 cycles
//       (WAIT, then OUT).
//   Ordering and handshake rules
//     - Window N+1 is not accepted until window N's output has transferred.
//     - in_valid may drop at any time without effect on in-flight state.
//     - out_valid never drops without a transfer (except on reset).
//   Comparator semantics
//     - Sign, NaN and +0/-0 semantics are the comparator's; this block only
//       trusts cmp_result for the value and uses cmp_gt for the index.
// TESTING
//   1. POOL_SIZE=4, inputs 3F000000,3F800000,40000000,3F800000 (0.5,1,2,1)
//      -> out_data=40000000, out_idx=2, win_count=1.
//   2. Equal inputs 3F800000 x4 -> out_data=3F800000, out_idx=0 (earliest tie).
//   3. Negative values BF800000,C0000000,BF000000,C0400000
//      -> out_data=BF000000 (-0.5), out_idx=2.
//   4. out_ready=0 for 10 cycles in OUT -> out_valid and out_data held stable,
//      in_ready=0, no input consumed; then released -> single transfer, back to IDLE.
//   5. Assert rst after 2 of 4 inputs -> all outputs 0 immediately; next 4 inputs
//      form a fresh window with correct max/idx.
//   6. POOL_SIZE=1, stream 5 values with out_ready=1 -> each value echoed with
//      out_idx=0; win_count=5.

Source files
------------

// File: rtl/pool_max_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_max_sequencer_if : input stream, comparator and output stream bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface pool_max_sequencer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int IDX_WIDTH  = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [DATA_WIDTH-1:0] cmp_a;
   logic [DATA_WIDTH-1:0] cmp_b;
   logic                  cmp_gt;
   logic [DATA_WIDTH-1:0] cmp_result;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [IDX_WIDTH-1:0]  out_idx;
   logic [15:0]           win_count;

   // master is the sequencer; slave is the surrounding buffers and comparator
   modport master (
      input  in_valid, in_data, cmp_gt, cmp_result, out_ready,
      output in_ready, cmp_a, cmp_b, out_valid, out_data, out_idx, win_count
   );
   modport slave (
      output in_valid, in_data, cmp_gt, cmp_result, out_ready,
      input  in_ready, cmp_a, cmp_b, out_valid, out_data, out_idx, win_count
   );
endinterface
`default_nettype wire

// File: rtl/pool_max_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_max_sequencer : windowed max-pooling using an external float comparator
// Rev 1.0
// ---------------------------------------------------------------------------
module pool_max_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int POOL_SIZE  = 4,
   parameter int IDX_WIDTH  = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   pool_max_sequencer_if.master  bus
);
   localparam logic [IDX_WIDTH-1:0] C_POOL_CNT = IDX_WIDTH'(POOL_SIZE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] max_q, max_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
   logic [IDX_WIDTH-1:0]  cur_idx_q, cur_idx_d;
   logic [DATA_WIDTH-1:0] cmp_a_q, cmp_a_d;
   logic [DATA_WIDTH-1:0] cmp_b_q, cmp_b_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [15:0]           win_count_q, win_count_d;

   logic w_in_fire;
   logic w_out_fire;

   assign w_in_fire  = bus.in_valid & in_ready_q;
   assign w_out_fire = out_valid_q & bus.out_ready;

   always_comb begin
      state_d     = state_q;
      max_d       = max_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      cur_idx_d   = cur_idx_q;
      cmp_a_d     = cmp_a_q;
      cmp_b_d     = cmp_b_q;
      win_count_d = win_count_q;

      case (state_q)
         S_IDLE: begin
            if (w_in_fire) begin
               max_d   = bus.in_data;
               idx_d   = '0;
               cnt_d   = IDX_WIDTH'(1);
               state_d = (POOL_SIZE == 1) ? S_OUT : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (w_in_fire) begin
               cmp_a_d   = max_q;
               cmp_b_d   = bus.in_data;
               cur_idx_d = cnt_q;
               cnt_d     = cnt_q + 1'b1;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            max_d = bus.cmp_result;
            // Equal operands keep the earlier index even if cmp_gt reports 0
            if (!bus.cmp_gt && (cmp_a_q != cmp_b_q)) begin
               idx_d = cur_idx_q;
            end
            state_d = (cnt_q == C_POOL_CNT) ? S_OUT : S_ACCUM;
         end
         S_OUT: begin
            if (w_out_fire) begin
               win_count_d = win_count_q + 16'd1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE) || (state_d == S_ACCUM);
      out_valid_d = (state_d == S_OUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         max_q       <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         cur_idx_q   <= '0;
         cmp_a_q     <= '0;
         cmp_b_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         win_count_q <= '0;
      end else begin
         state_q     <= state_d;
         max_q       <= max_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         cur_idx_q   <= cur_idx_d;
         cmp_a_q     <= cmp_a_d;
         cmp_b_q     <= cmp_b_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         win_count_q <= win_count_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = max_q;
   assign bus.out_idx   = idx_q;
   assign bus.cmp_a     = cmp_a_q;
   assign bus.cmp_b     = cmp_b_q;
   assign bus.win_count = win_count_q;
endmodule
`default_nettype wire
